// File: rtl/mem_port_arbiter_if.sv
// Requester, stall and memory-side signals of mem_port_arbiter.
// slave = arbiter view, master = pipeline/memory environment view.
interface mem_port_arbiter_if #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
);
  logic              if_req;
  logic [AWIDTH-1:0] if_addr;
  logic              if_rvalid;
  logic [DWIDTH-1:0] if_rdata;

  logic              dm_req;
  logic              dm_we;
  logic [AWIDTH-1:0] dm_addr;
  logic [DWIDTH-1:0] dm_wdata;
  logic [2:0]        dm_size;
  logic              dm_rvalid;
  logic [DWIDTH-1:0] dm_rdata;

  logic              stall_f;
  logic              stall_m;

  logic              mem_req;
  logic              mem_we;
  logic [AWIDTH-1:0] mem_addr;
  logic [DWIDTH-1:0] mem_wdata;
  logic [2:0]        mem_size;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DWIDTH-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_rvalid, if_rdata,
    input  dm_req, dm_we, dm_addr, dm_wdata, dm_size,
    output dm_rvalid, dm_rdata,
    output stall_f, stall_m,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_size,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_rvalid, if_rdata,
    output dm_req, dm_we, dm_addr, dm_wdata, dm_size,
    input  dm_rvalid, dm_rdata,
    input  stall_f, stall_m,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_size,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port multi-cycle memory between fetch (IF) and data (DM) requesters.
// Optional IF starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
  parameter int AWIDTH     = 32,
  parameter int DWIDTH     = 32,
  parameter int STREAK_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;
  typedef enum logic {OWN_IF, OWN_DM} owner_t;

  // Instruction fetches are always full words (LW size code).
  localparam logic [2:0] FETCH_SIZE = 3'b010;

  if (STREAK_MAX < 1 || STREAK_MAX > 7) begin : g_bad_streak
    $error("STREAK_MAX must fit the 3-bit streak counter");
  end

  state_t            state;
  owner_t            owner;
  logic              if_rvalid_q;
  logic              dm_rvalid_q;
  logic [DWIDTH-1:0] if_rdata_q;
  logic [DWIDTH-1:0] dm_rdata_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [AWIDTH-1:0] mem_addr_q;
  logic [DWIDTH-1:0] mem_wdata_q;
  logic [2:0]        mem_size_q;
  logic              pick_if;

`ifdef ARB_STARVE_GUARD_EN
  logic [2:0] streak;
  assign pick_if = bus.if_req && (!bus.dm_req || (streak == 3'(STREAK_MAX)));
`else
  assign pick_if = bus.if_req && !bus.dm_req;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      owner       <= OWN_IF;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_size_q  <= '0;
`ifdef ARB_STARVE_GUARD_EN
      streak      <= '0;
`endif
    end else begin
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.if_req || bus.dm_req) begin
            state     <= REQ;
            mem_req_q <= 1'b1;
            if (pick_if) begin
              owner       <= OWN_IF;
              mem_we_q    <= 1'b0;
              mem_addr_q  <= bus.if_addr;
              mem_wdata_q <= '0;
              mem_size_q  <= FETCH_SIZE;
            end else begin
              owner       <= OWN_DM;
              mem_we_q    <= bus.dm_we;
              mem_addr_q  <= bus.dm_addr;
              mem_wdata_q <= bus.dm_wdata;
              mem_size_q  <= bus.dm_size;
            end
`ifdef ARB_STARVE_GUARD_EN
            if (!pick_if && bus.if_req) streak <= streak + 3'd1;
            else                        streak <= '0;
`endif
          end
        end
        REQ: begin
          if (bus.mem_gnt) begin
            state     <= RSP;
            mem_req_q <= 1'b0;
          end
        end
        RSP: begin
          if (bus.mem_rvalid) begin
            state <= IDLE;
            // A requester that withdrew mid-access gets neither data nor a pulse.
            if (owner == OWN_DM) begin
              if (bus.dm_req) begin
                dm_rdata_q  <= bus.mem_rdata;
                dm_rvalid_q <= 1'b1;
              end
            end else begin
              if (bus.if_req) begin
                if_rdata_q  <= bus.mem_rdata;
                if_rvalid_q <= 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.if_rvalid = if_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rvalid = dm_rvalid_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_size  = mem_size_q;
  assign bus.stall_f   = bus.if_req && !if_rvalid_q;
  assign bus.stall_m   = bus.dm_req && !dm_rvalid_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter: the bench plays both the pipeline
// requesters and the memory, with hand-computed latencies and data.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic reset;
  int unsigned nchk = 0;
  int unsigned nerr = 0;
  logic [31:0] last_if = '0;
  logic [31:0] last_dm = '0;

  mem_port_arbiter_if #(.AWIDTH(32), .DWIDTH(32)) bus ();

  mem_port_arbiter #(.AWIDTH(32), .DWIDTH(32), .STREAK_MAX(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_dm;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  size;      // DM: driven size; IF: expected fetch size
    int unsigned gnt_wait;
    int unsigned rsp_wait;
    bit          spurious;  // pulse mem_rvalid while still waiting for grant
    logic [31:0] rdata;
    int unsigned exp_lat;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Requests may only drop in or right after their rvalid cycle.
  bit p_rst, p_if_req, p_dm_req, p_if_rv, p_dm_rv;
  always @(posedge clk) begin
    if (p_rst && reset) begin
      assert (!(p_if_req && !bus.if_req && !p_if_rv && !bus.if_rvalid))
        else $error("protocol: if_req withdrawn before if_rvalid");
      assert (!(p_dm_req && !bus.dm_req && !p_dm_rv && !bus.dm_rvalid))
        else $error("protocol: dm_req withdrawn before dm_rvalid");
    end
    p_rst    <= reset;
    p_if_req <= bus.if_req;
    p_dm_req <= bus.dm_req;
    p_if_rv  <= bus.if_rvalid;
    p_dm_rv  <= bus.dm_rvalid;
  end

  task automatic do_access(input vec_t v);
    int unsigned cyc = 0;
    int unsigned req_cyc = 0;
    int unsigned rsp_cyc = 0;
    bit granted = 0;
    bit done = 0;
    logic [35:0] exp_cmd = {v.we, v.size, v.wdata};
    if (v.is_dm) begin
      bus.dm_req = 1'b1; bus.dm_we = v.we; bus.dm_addr = v.addr;
      bus.dm_wdata = v.wdata; bus.dm_size = v.size;
    end else begin
      bus.if_req = 1'b1; bus.if_addr = v.addr;
    end
    #1;
    check("stall at request", 64'(v.is_dm ? bus.stall_m : bus.stall_f), 64'd1);
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      bus.mem_gnt = 1'b0;
      bus.mem_rvalid = 1'b0;
      if (v.is_dm ? bus.dm_rvalid : bus.if_rvalid) begin
        check("latency", 64'(cyc), 64'(v.exp_lat));
        check("rdata", 64'(v.is_dm ? bus.dm_rdata : bus.if_rdata), 64'(v.rdata));
        check("stall in rvalid cycle", 64'(v.is_dm ? bus.stall_m : bus.stall_f), 64'd0);
        check("other rdata held", 64'(v.is_dm ? bus.if_rdata : bus.dm_rdata),
              64'(v.is_dm ? last_if : last_dm));
        if (v.is_dm) begin last_dm = v.rdata; bus.dm_req = 1'b0; end
        else         begin last_if = v.rdata; bus.if_req = 1'b0; end
        done = 1'b1;
      end else if (!granted) begin
        if (bus.mem_req) begin
          check("mem_addr", 64'(bus.mem_addr), 64'(v.addr));
          check("mem cmd", 64'({bus.mem_we, bus.mem_size, bus.mem_wdata}), 64'(exp_cmd));
          if (req_cyc == v.gnt_wait) begin
            bus.mem_gnt = 1'b1;
            granted = 1'b1;
          end else if (req_cyc == 0 && v.spurious) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata = 32'hBAD0_BAD0;
          end
          req_cyc++;
        end
      end else begin
        if (rsp_cyc == v.rsp_wait) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata = v.rdata;
        end
        rsp_cyc++;
      end
    end
    check("access completed", 64'(done), 64'd1);
    @(negedge clk);
    check("single rvalid pulse", 64'({bus.if_rvalid, bus.dm_rvalid}), 64'd0);
    check("idle after access", 64'(bus.mem_req), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit pend_rsp;
    int unsigned n;
    bit exp_if;

    vecs[0] = '{0, 0, 32'h0000_0010, 32'h0, 3'd2, 0, 0, 0, 32'h0050_0093, 3};
    vecs[1] = '{1, 0, 32'h0000_0200, 32'h0, 3'd2, 0, 2, 0, 32'h1234_5678, 5};
    vecs[2] = '{1, 1, 32'h0000_0100, 32'hDEAD_BEEF, 3'd2, 1, 0, 0, 32'h0000_0001, 4};
    vecs[3] = '{0, 0, 32'h0000_0014, 32'h0, 3'd2, 5, 1, 1, 32'hFFFF_FFFF, 9};
    vecs[4] = '{1, 0, 32'hFFFF_FFFC, 32'h0, 3'd5, 1, 0, 0, 32'h8000_0001, 4};
    vecs[5] = '{0, 0, 32'h0000_0018, 32'h0, 3'd2, 2, 3, 0, 32'h0000_0013, 8};

    reset = 1'b0;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0; bus.dm_size = '0;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    repeat (2) @(negedge clk);
    check("reset mem cmd", 64'({bus.mem_req, bus.mem_we, bus.mem_size, bus.mem_addr}), 64'd0);
    check("reset mem_wdata", 64'(bus.mem_wdata), 64'd0);
    check("reset rvalids", 64'({bus.if_rvalid, bus.dm_rvalid}), 64'd0);
    check("reset stalls idle", 64'({bus.stall_f, bus.stall_m}), 64'd0);

    // Reset held with both requests up, then store/fetch collision on release.
    bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 32'h100;
    bus.dm_wdata = 32'hDEAD_BEEF; bus.dm_size = 3'd2;
    bus.if_req = 1'b1; bus.if_addr = 32'h10;
    repeat (2) @(negedge clk);
    check("reset mem_req with requests", 64'(bus.mem_req), 64'd0);
    check("reset rvalids with requests", 64'({bus.if_rvalid, bus.dm_rvalid}), 64'd0);
    check("reset rdata", 64'({bus.if_rdata, bus.dm_rdata}), 64'd0);
    check("reset stalls busy", 64'({bus.stall_f, bus.stall_m}), 64'd3);
    reset = 1'b1;
    @(negedge clk);
    check("collision first mem_req", 64'(bus.mem_req), 64'd1);
    check("collision store addr", 64'(bus.mem_addr), 64'h100);
    check("collision store cmd", 64'({bus.mem_we, bus.mem_size, bus.mem_wdata}),
          64'({1'b1, 3'd2, 32'hDEAD_BEEF}));
    bus.mem_gnt = 1'b1;
    @(negedge clk);
    bus.mem_gnt = 1'b0;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0000_0777;
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    check("collision dm_rvalid", 64'(bus.dm_rvalid), 64'd1);
    check("collision dm_rdata", 64'(bus.dm_rdata), 64'h777);
    check("collision IF not yet issued", 64'(bus.mem_req), 64'd0);
    check("collision stalls", 64'({bus.stall_f, bus.stall_m}), 64'd2);
    bus.dm_req = 1'b0;
    @(negedge clk);
    check("collision IF back-to-back", 64'(bus.mem_req), 64'd1);
    check("collision IF cmd", 64'({bus.mem_we, bus.mem_size, bus.mem_addr}),
          64'({1'b0, 3'd2, 32'h10}));
    bus.mem_gnt = 1'b1;
    @(negedge clk);
    bus.mem_gnt = 1'b0;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0050_0093;
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    check("collision if_rvalid", 64'(bus.if_rvalid), 64'd1);
    check("collision if_rdata", 64'(bus.if_rdata), 64'h0050_0093);
    bus.if_req = 1'b0;
    last_dm = 32'h777;
    last_if = 32'h0050_0093;
    @(negedge clk);
    check("collision quiet", 64'({bus.if_rvalid, bus.dm_rvalid, bus.mem_req}), 64'd0);

    for (int i = 0; i < 6; i++) do_access(vecs[i]);

    // Reset while waiting for the response: the late response must vanish.
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h400; bus.dm_size = 3'd2;
    @(negedge clk);
    check("rst-rsp mem_req", 64'(bus.mem_req), 64'd1);
    bus.mem_gnt = 1'b1;
    @(negedge clk);
    bus.mem_gnt = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1; bus.dm_req = 1'b0;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0000_0055;
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    check("rst-rsp no rvalid", 64'({bus.if_rvalid, bus.dm_rvalid, bus.mem_req}), 64'd0);
    check("rst-rsp rdata cleared", 64'(bus.dm_rdata), 64'd0);
    @(negedge clk);
    check("rst-rsp still no rvalid", 64'({bus.if_rvalid, bus.dm_rvalid}), 64'd0);

    // Both requesters permanently busy: grant order shows the starvation policy.
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h300; bus.dm_size = 3'd2;
    bus.if_req = 1'b1; bus.if_addr = 32'h40;
    pend_rsp = 1'b0;
    n = 0;
    for (int c = 0; c < 300 && n < 10; c++) begin
      @(negedge clk);
      bus.mem_gnt = 1'b0;
      bus.mem_rvalid = 1'b0;
      if (pend_rsp) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata = 32'h1000 + n;
        pend_rsp = 1'b0;
      end else if (bus.mem_req) begin
`ifdef ARB_STARVE_GUARD_EN
        exp_if = (n % 5) == 4;
`else
        exp_if = 1'b0;
`endif
        check($sformatf("grant %0d owner", n), 64'(bus.mem_addr),
              exp_if ? 64'h40 : 64'h300);
        bus.mem_gnt = 1'b1;
        pend_rsp = 1'b1;
        n++;
      end
    end
    check("grant count", 64'(n), 64'd10);
    @(negedge clk);
    bus.mem_gnt = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    bus.dm_req = 1'b0; bus.if_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer that shares one single-port, multi-cycle unified memory between the fetch stage (IF) and the memory stage (MEM) of the 5-stage RISC-V pipeline. It serialises requests, drives the memory handshake, and returns read data to the winning requester. It also produces stall signals that hold PC_reg, Reg_IF_ID and the downstream pipeline registers while an access is in flight.

## Interface
- AWIDTH, 32, address width
- DWIDTH, 32, data width
- STREAK_MAX, 4, consecutive MEM grants allowed before a waiting IF request must win (guard feature only)

- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-low; one clock, reset is synchronous and active-low
- if_req  in  1  fetch read request, held until if_rvalid
- if_addr  in  AWIDTH  fetch address (pc_f)
- if_rvalid  out  1  one-cycle pulse, if_rdata valid
- if_rdata  out  DWIDTH  fetched instruction
- dm_req  in  1  data request, held until dm_rvalid
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  AWIDTH  data address (alu_out_mem)
- dm_wdata  in  DWIDTH  store data
- dm_size  in  3  size_type code, passed through unchanged
- dm_rvalid  out  1  one-cycle pulse, load data valid or store done
- dm_rdata  out  DWIDTH  load data
- stall_f  out  1  hold PC and IF/ID
- stall_m  out  1  hold EX/MEM and MEM/WB, and squash writeback
- mem_req  out  1  request to memory
- mem_we, mem_addr, mem_wdata, mem_size  out  1/AWIDTH/DWIDTH/3  latched command
- mem_gnt  in  1  memory accepts the command this cycle
- mem_rvalid  in  1  response, for both reads and writes
- mem_rdata  in  DWIDTH  response data

## Operation
- FSM states: IDLE, REQ, RSP.
- IDLE: if any request is pending, select the owner, latch its command into the mem_* registers, and go to REQ. If no request is pending, stay in IDLE.
- Priority: dm_req beats if_req. The owner register records which requester won (IF or DM).
- REQ: mem_req=1. When mem_gnt=1, go to RSP. mem_rvalid is ignored in REQ.
- RSP: mem_req=0. When mem_rvalid=1, register mem_rdata into the owner's rdata, pulse the owner's rvalid the next cycle, and return to IDLE.
- In the cycle the rvalid pulse is driven, a new arbitration may occur. IDLE is evaluated in that same cycle, so back-to-back accesses are allowed.
- stall_f = if_req && !if_rvalid.
- stall_m = dm_req && !dm_rvalid.
- The command is latched only at arbitration. Requester inputs may change afterwards without effect.
- Any request that drops before its completion is an illegal protocol condition and must be flagged by a bench assertion. The RTL completes the transaction anyway and discards the data.
- dm_rdata and if_rdata hold their last value until the next completion for that requester.

## Timing
- Reset (reset=0 at a clk edge) sets:
  - state IDLE
  - all mem_* outputs 0
  - if_rvalid and dm_rvalid 0
  - if_rdata and dm_rdata 0
  - streak counter 0
- stall_f and stall_m are combinational and therefore 0 while requests are 0.
- Reset asserted mid-transaction aborts it: the state returns to IDLE, the pending response is dropped, and no rvalid pulse is produced.
- Latency:
  - request seen in IDLE at cycle 0
  - mem_req high from cycle 1
  - gnt at cycle g ≥ 1
  - mem_rvalid at cycle r > g
  - owner rvalid at cycle r+1
- Best case from request to rvalid is 3 cycles.
- Simultaneous if_req and dm_req in IDLE: DM wins and IF waits with stall_f=1.
- If mem_gnt and mem_rvalid are high in the same REQ cycle, the rvalid is ignored. The memory must not do this.

## Configuration
- ARB_STARVE_GUARD_EN defined:
  - A 3-bit streak counter increments on each DM grant made while if_req=1.
  - The counter clears on any IF grant, or on a DM grant made with if_req=0.
  - When the counter equals STREAK_MAX and if_req=1, IF wins the next arbitration and the counter clears.
- Undefined: strict DM-over-IF priority, and no counter logic.

## Test plan
- Reset behaviour:
  - Stimulus: hold reset=0 for 2 cycles with both requests high.
  - Required: mem_req=0, rvalids=0, rdata=0, state IDLE.
  - Release reset: DM arbitrates first.
- Single fetch:
  - Stimulus: if_addr=0x10; memory gives gnt at cycle 1 and rvalid with 0x00500093 at cycle 2.
  - Required: if_rvalid at cycle 3 with if_rdata=0x00500093; stall_f=1 during cycles 0-2.
- Store then fetch collision:
  - Stimulus: dm_we=1, dm_addr=0x100, dm_wdata=0xDEADBEEF, dm_size=2, with if_req raised in the same cycle.
  - Required: the memory sees the store command first; dm_rvalid arrives before the IF command is issued; if_rvalid follows.
- Delayed grant:
  - Stimulus: mem_gnt held low for 5 cycles.
  - Required: mem_req stays 1 with a stable command; exactly one rvalid pulse is produced.
- Reset mid-RSP:
  - Stimulus: assert reset while in RSP, then deliver mem_rvalid.
  - Required: no dm_rvalid or if_rvalid pulse.
- Starvation guard:
  - Stimulus: ARB_STARVE_GUARD_EN defined, dm_req and if_req both continuously high.
  - Required: 4 DM grants, then 1 IF grant, repeating.
  - With the macro undefined, IF is never granted.
